// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin (with HOST burst override) between
// the CPU and HOST requesters, byte/half/word to word-aligned conversion, and
// load extraction with sign/zero extension. Three cycles per access.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [1:0]        cpu_width,
  input  logic              cpu_sign,
  input  logic [31:0]       cpu_wdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [1:0]        host_width,
  input  logic              host_sign,
  input  logic [31:0]       host_wdata,
  input  logic              host_lock,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              host_ack,
  output logic              host_err,
  output logic [31:0]       host_rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  state_t state, state_nxt;

  logic              last_grant;  // 1 = HOST
  logic [3:0]        burst_cnt;
  logic              sel_q;       // 1 = HOST owns the current access
  logic              we_q, sign_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        width_q;
  logic [31:0]       wdata_q;

  logic              grant_any, grant_host;
  logic              req_we, req_sign, req_err;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_width;
  logic [31:0]       req_wdata;

  logic [1:0]        lane;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       rd_ext;

  // Arbitration and selection of the winning request's fields
  always_comb begin
    grant_any = cpu_req | host_req;
    if (cpu_req && host_req) begin
      if (host_lock && last_grant && (burst_cnt < BURST_LIM))
        grant_host = 1'b1;
      else
        grant_host = ~last_grant;
    end else begin
      grant_host = host_req;
    end
    req_we    = grant_host ? host_we    : cpu_we;
    req_sign  = grant_host ? host_sign  : cpu_sign;
    req_addr  = grant_host ? host_addr  : cpu_addr;
    req_width = grant_host ? host_width : cpu_width;
    req_wdata = grant_host ? host_wdata : cpu_wdata;
    req_err   = (req_width == 2'b11) ||
                ((req_width == 2'b01) && req_addr[0]) ||
                ((req_width == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the granted request and maintain fairness/burst bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      burst_cnt  <= '0;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      sign_q     <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      width_q    <= '0;
      wdata_q    <= '0;
    end else begin
      if (state == IDLE && grant_any) begin
        last_grant <= grant_host;
        sel_q      <= grant_host;
        we_q       <= req_we;
        sign_q     <= req_sign;
        err_q      <= req_err;
        addr_q     <= req_addr;
        width_q    <= req_width;
        wdata_q    <= req_wdata;
      end
      if (!host_lock)
        burst_cnt <= '0;
      else if (state == IDLE && grant_any) begin
        if (!grant_host)
          burst_cnt <= '0;
        else if (cpu_req)
          burst_cnt <= burst_cnt + 4'd1;
      end
    end
  end

  // Load extraction from the returned memory word
  always_comb begin
    lane    = addr_q[1:0];
    rd_byte = mem_rdata[{lane, 3'b000} +: 8];
    rd_half = mem_rdata[{lane[1], 4'b0000} +: 16];
    unique case (width_q)
      2'b00:   rd_ext = {{24{sign_q & rd_byte[7]}}, rd_byte};
      2'b01:   rd_ext = {{16{sign_q & rd_half[15]}}, rd_half};
      default: rd_ext = mem_rdata;
    endcase
  end

  // Memory strobes in ISSUE, completion signalling in RESP
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cpu_ack    = 1'b0;
    cpu_err    = 1'b0;
    cpu_rdata  = '0;
    host_ack   = 1'b0;
    host_err   = 1'b0;
    host_rdata = '0;
    if (state == ISSUE && !err_q) begin
      mem_en   = 1'b1;
      mem_we   = we_q;
      mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
      unique case (width_q)
        2'b00:   begin mem_be = 4'b0001 << lane; mem_wdata = {4{wdata_q[7:0]}};  end
        2'b01:   begin mem_be = 4'b0011 << lane; mem_wdata = {2{wdata_q[15:0]}}; end
        default: begin mem_be = 4'b1111;         mem_wdata = wdata_q;            end
      endcase
    end
    if (state == RESP) begin
      if (sel_q) begin
        host_ack   = 1'b1;
        host_err   = err_q;
        host_rdata = (err_q || we_q) ? '0 : rd_ext;
      end else begin
        cpu_ack   = 1'b1;
        cpu_err   = err_q;
        cpu_rdata = (err_q || we_q) ? '0 : rd_ext;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_ack;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_sign;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [1:0]  cpu_width;
  logic        host_req, host_we, host_sign, host_lock;
  logic [31:0] host_addr, host_wdata;
  logic [1:0]  host_width;
  logic        cpu_ack, cpu_err, cpu_stall, host_ack, host_err, busy;
  logic [31:0] cpu_rdata, host_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Small word memory with byte-enable writes and one-cycle read latency
  logic [31:0] mem [0:15];
  logic        poke_en = 1'b0;
  logic [3:0]  poke_idx = '0;
  logic [31:0] poke_data = '0;

  dmem_arbiter #(.ADDR_W(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_width(cpu_width),
    .cpu_sign(cpu_sign), .cpu_wdata(cpu_wdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_width(host_width),
    .host_sign(host_sign), .host_wdata(host_wdata), .host_lock(host_lock),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model
  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_data;
    if (mem_en) begin
      if (mem_we) begin
        for (int k = 0; k < 4; k++)
          if (mem_be[k]) mem[mem_addr[5:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[5:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [3:0] idx, input logic [31:0] data);
    poke_en = 1'b1; poke_idx = idx; poke_data = data;
    tick();
    poke_en = 1'b0;
  endtask

  // One full access from port h (0 = CPU, 1 = HOST), checked every cycle
  task automatic do_access(input string nm, input bit h, input bit we,
                           input logic [31:0] addr, input logic [1:0] w, input bit sg,
                           input logic [31:0] wd, input bit exp_en, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input bit exp_er, input logic [31:0] exp_rd);
    if (h) begin
      host_we = we; host_addr = addr; host_width = w; host_sign = sg; host_wdata = wd;
      host_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_width = w; cpu_sign = sg; cpu_wdata = wd;
      cpu_req = 1'b1;
    end
    #1;
    if (!h) chk({nm, ".stall_t0"}, 32'(cpu_stall), 32'd1);
    tick();
    chk({nm, ".en"}, 32'(mem_en), 32'(exp_en));
    if (exp_en) begin
      chk({nm, ".we"},    32'(mem_we), 32'(we));
      chk({nm, ".be"},    32'(mem_be), 32'(exp_be));
      chk({nm, ".addr"},  mem_addr, {addr[31:2], 2'b00});
      if (we) chk({nm, ".wdata"}, mem_wdata, exp_wd);
    end
    if (!h) chk({nm, ".stall_t1"}, 32'(cpu_stall), 32'd1);
    tick();
    chk({nm, ".ack"},   h ? 32'(host_ack) : 32'(cpu_ack), 32'd1);
    chk({nm, ".other"}, h ? 32'(cpu_ack) : 32'(host_ack), 32'd0);
    chk({nm, ".err"},   h ? 32'(host_err) : 32'(cpu_err), 32'(exp_er));
    chk({nm, ".rdata"}, h ? host_rdata : cpu_rdata, exp_rd);
    chk({nm, ".en_resp"}, 32'(mem_en), 32'd0);
    if (!h) chk({nm, ".stall_t2"}, 32'(cpu_stall), 32'd0);
    cpu_req = 1'b0; host_req = 1'b0;
    tick();
    chk({nm, ".idle"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_width = 2'b10; cpu_sign = 0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_width = 2'b10; host_sign = 0; host_wdata = '0;
    host_lock = 0;
    mem_rdata = '0;
    tick(); tick();
    chk("rst.busy",  32'(busy), 32'd0);
    chk("rst.ack",   {30'd0, cpu_ack, host_ack}, 32'd0);
    chk("rst.en",    32'(mem_en), 32'd0);
    chk("rst.rdata", cpu_rdata | host_rdata, 32'd0);
    chk("rst.stall", 32'(cpu_stall), 32'd0);
    cpu_req = 1'b1; #1;
    chk("rst.stall_follow", 32'(cpu_stall), 32'd1);
    cpu_req = 1'b0;
    rst = 1'b0;
    tick();

    poke(4'd4, 32'h11223344);
    do_access("lw10",  0, 0, 32'h10, 2'b10, 0, 0, 1, 4'b1111, 0, 0, 32'h11223344);
    poke(4'd4, 32'h80FF0000);
    do_access("lb13s", 0, 0, 32'h13, 2'b00, 1, 0, 1, 4'b1000, 0, 0, 32'hFFFFFF80);
    do_access("lb13u", 0, 0, 32'h13, 2'b00, 0, 0, 1, 4'b1000, 0, 0, 32'h00000080);
    do_access("sh06",  0, 1, 32'h06, 2'b01, 0, 32'h0000ABCD, 1, 4'b1100, 32'hABCDABCD, 0, 0);
    do_access("lh06s", 0, 0, 32'h06, 2'b01, 1, 0, 1, 4'b1100, 0, 0, 32'hFFFFABCD);
    do_access("lh06u", 0, 0, 32'h06, 2'b01, 0, 0, 1, 4'b1100, 0, 0, 32'h0000ABCD);
    do_access("lw05",  0, 0, 32'h05, 2'b10, 0, 0, 0, 4'b0000, 0, 1, 0);
    do_access("lh03",  0, 0, 32'h03, 2'b01, 0, 0, 0, 4'b0000, 0, 1, 0);
    do_access("rsvd",  0, 0, 32'h00, 2'b11, 0, 0, 0, 4'b0000, 0, 1, 0);
    do_access("sb01",  0, 1, 32'h01, 2'b00, 0, 32'h0000005A, 1, 4'b0010, 32'h5A5A5A5A, 0, 0);
    do_access("hsw20", 1, 1, 32'h20, 2'b10, 0, 32'hDEADBEEF, 1, 4'b1111, 32'hDEADBEEF, 0, 0);
    do_access("hlb21", 1, 0, 32'h21, 2'b00, 0, 0, 1, 4'b0010, 0, 0, 32'h000000BE);
    do_access("hlb22", 1, 0, 32'h22, 2'b00, 1, 0, 1, 4'b0100, 0, 0, 32'hFFFFFFAD);

    // Round-robin with both ports requesting continuously
    do_reset();
    cpu_we = 0;  cpu_addr = 32'h10;  cpu_width = 2'b10;
    host_we = 0; host_addr = 32'h20; host_width = 2'b10;
    cpu_req = 1; host_req = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr.en", 32'(mem_en), 32'd1);
      tick();
      chk("rr.cpu_ack",  32'(cpu_ack),  (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr.host_ack", 32'(host_ack), (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr.stall",    32'(cpu_stall), (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
    end
    cpu_req = 0; host_req = 0;

    // Burst override: four HOST grants, then CPU, then reset mid-RESP
    do_reset();
    host_lock = 1;
    cpu_req = 1; host_req = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      tick();
      chk("burst.host_ack", 32'(host_ack), (k < 4) ? 32'd1 : 32'd0);
      chk("burst.cpu_ack",  32'(cpu_ack),  (k < 4) ? 32'd0 : 32'd1);
      tick();
    end
    tick();
    tick();
    chk("midrst.pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.ack",  {30'd0, cpu_ack, host_ack}, 32'd0);
    chk("midrst.en",   32'(mem_en), 32'd0);
    cpu_req = 0; host_req = 0; host_lock = 0;
    tick();
    rst = 1'b0;
    tick();
    chk("midrst.after", {30'd0, cpu_ack, host_ack}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-ported data memory behind the MIPS core. It shares the memory between the core's load/store port (CPU) and a host/loader port (HOST). It converts byte/half/word accesses into word-aligned memory cycles with byte enables, and performs load extraction with sign or zero extension. It sits between `mips` and `dmem` inside `Top`, and drives the core's stall input.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width for both requesters.
- `MAX_BURST`, 4, maximum consecutive HOST grants under `host_lock` while CPU is waiting (1..15).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_req`, `host_req`  in  1  access request; held with its fields until the matching ack.
- `cpu_we`, `host_we`  in  1  1 = store, 0 = load.
- `cpu_addr`, `host_addr`  in  ADDR_W  byte address.
- `cpu_width`, `host_width`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `cpu_sign`, `host_sign`  in  1  1 = sign-extend loads, 0 = zero-extend.
- `cpu_wdata`, `host_wdata`  in  32  store data, right-justified.
- `host_lock`  in  1  HOST burst request.
- `cpu_ack`, `host_ack`  out  1  one-cycle completion pulse.
- `cpu_err`, `host_err`  out  1  valid with ack; 1 = misaligned or reserved width, no memory access.
- `cpu_rdata`, `host_rdata`  out  32  load result; valid with ack, 0 otherwise.
- `cpu_stall`  out  1  `cpu_req & ~cpu_ack`, combinational.
- `busy`  out  1  state != IDLE.
- `mem_en`, `mem_we`  out  1  memory cycle strobe / write.
- `mem_be`  out  4  byte enables, bit k = bits [8k+7:8k].
- `mem_addr`  out  ADDR_W  `{addr[ADDR_W-1:2], 2'b00}`.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rdata`  in  32  memory read word, valid the cycle after `mem_en`.

## Operation
- FSM states: IDLE, ISSUE, RESP. Transitions are IDLE→ISSUE when any req is high, ISSUE→RESP always, and RESP→IDLE always.
- In IDLE, the arbiter picks the winner and latches `sel`, we, addr, width, sign, wdata and the alignment check.
- Round-robin arbitration: with one req, grant it. With both, grant the port not granted last. `last_grant` resets to HOST, so CPU wins the first tie.
- Burst override: if `host_lock`=1, `last_grant`=HOST and `burst_cnt` < `MAX_BURST`, HOST wins the tie.
  - `burst_cnt` increments on each HOST grant made while `cpu_req`=1.
  - `burst_cnt` clears on any CPU grant or when `host_lock`=0.
- Little-endian lanes; `lane = addr[1:0]`.
  - Byte access: `be = 1<<lane`.
  - Half access: `be = 0011<<lane`.
  - Word access: `be = 1111`.
- Store data replication: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word `wdata`.
- Error conditions: half with `addr[0]`=1, word with `addr[1:0]`≠0, or width 11. On error, ISSUE keeps `mem_en`=0, and RESP asserts ack with err=1 and rdata=0.
- Load extraction in RESP:
  - Byte: select `mem_rdata[8*lane+:8]`.
  - Half: select `mem_rdata[8*lane+:16]`.
  - Extend to 32 bits per the latched sign.
  - Stores return rdata=0.

## Timing
- Reset (async, immediate) values: state=IDLE, `last_grant`=HOST, `burst_cnt`=0. All outputs are 0, except `cpu_stall`, which follows `cpu_req`.
- Request sampled high in IDLE at cycle T:
  - ISSUE in T+1: `mem_en`=1 for exactly one cycle, with `mem_we`/`mem_be`/`mem_addr`/`mem_wdata` from the latched fields.
  - RESP in T+2: ack pulse, plus rdata/err from `mem_rdata` (combinational path).
  - IDLE in T+3.
- Minimum 3 cycles per access. Back-to-back accesses from one port therefore have a 3-cycle period.
- A requester seeing ack in RESP may keep req high. It is re-sampled in the following IDLE cycle as a new request.
- Memory outputs are 0 in IDLE and RESP.
- Simultaneous requests in IDLE: exactly one grant per the rules above. The loser stays pending, and `cpu_stall` stays high if CPU is the loser.
- Reset mid-ISSUE/RESP: the access is abandoned, no ack is generated, and outputs go to 0. A write already strobed in ISSUE may have been performed.
- Changing req fields before ack is illegal. The arbiter uses the latched copy.

## Test plan
- CPU load word at 0x10 with memory word 0x11223344 and no host activity → `mem_en` at T+1 with `be`=1111 and `mem_addr`=0x10. At T+2, `cpu_ack`=1 and `cpu_rdata`=0x11223344. `cpu_stall` is high for T..T+1.
- CPU load byte at 0x13, sign=1, memory word 0x80FF0000 → `cpu_rdata`=0xFFFFFF80. With sign=0 → 0x00000080.
- CPU store half 0xABCD at 0x06 → `mem_we`=1, `mem_be`=1100, `mem_addr`=0x04, `mem_wdata`=0xABCDABCD. Ack at T+2 with err=0.
- CPU load word at 0x05 → `mem_en` stays 0 throughout. Ack at T+2 with `cpu_err`=1 and `cpu_rdata`=0.
- Both ports requesting continuously with `host_lock`=0 → after reset, grants alternate CPU, HOST, CPU, HOST, with one ack every 3 cycles.
- `host_lock`=1 with both ports requesting, `MAX_BURST`=4, HOST granted first → 4 consecutive HOST grants, then a CPU grant. Assert `rst` during a RESP → no ack is produced and `busy`=0 immediately.
